i2c_xlate_master: RTL

Parametrised I2C master with an on-chip logical-to-physical address translation table. It generalises the single-byte, fixed-mapping translator to a programmable table of NUM_MAP entries, multi-byte reads and writes, and ACK/NACK reporting. It sits between the system-side request interface (enable/rw/addr/data) and the open-drain I2C pads. It generates START, address, data and STOP itself.

---
 rtl/i2c_xlate_master.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_xlate_master.sv
// I2C master with a programmable logical-to-physical slave address table.
// Define I2C_XLATE_PASSTHRU_EN to send unmapped addresses to the bus unchanged.
module i2c_xlate_master #(
  parameter  int unsigned CLK_DIV = 4,
  parameter  int unsigned NUM_MAP = 4,
  localparam int unsigned IW      = (NUM_MAP > 1) ? $clog2(NUM_MAP) : 1
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          map_we,
  input  logic [IW-1:0] map_idx,
  input  logic [6:0]    map_log,
  input  logic [6:0]    map_phy,
  input  logic          enable,
  input  logic          rw,
  input  logic [6:0]    addr,
  input  logic [7:0]    len,
  input  logic [7:0]    data_in,
  output logic          data_req,
  output logic [7:0]    data_out,
  output logic          data_valid,
  output logic          busy,
  output logic          done,
  output logic          nack,
  output logic          xlate_err,
  output logic          scl_o,
  output logic          sda_o,
  input  logic          sda_i
);

  localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW:0] NUM_MAP_W = (IW + 1)'(NUM_MAP);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_START, S_ADDR, S_AACK,
    S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rw_q, rw_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [6:0]    phys_q, phys_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          data_req_q, data_req_d;
  logic          data_valid_q, data_valid_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          xlate_err_q, xlate_err_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;

  logic [NUM_MAP-1:0] map_v_q;
  logic [6:0]         map_log_q [NUM_MAP];
  logic [6:0]         map_phy_q [NUM_MAP];

  logic       hit;
  logic [6:0] hit_phy;
  logic       tick_last, bit_end, sample, map_wr;

  assign map_wr    = map_we && ({1'b0, map_idx} < NUM_MAP_W);
  assign tick_last = (tick_q == TW'(CLK_DIV - 1));
  assign bit_end   = tick_last && (phase_q == 2'd3);
  assign sample    = tick_last && (phase_q == 2'd2);

  // Lowest valid matching index wins; reads registered table, so a same-cycle write is not seen.
  always_comb begin
    hit     = 1'b0;
    hit_phy = '0;
    for (int unsigned i = 0; i < NUM_MAP; i++) begin
      if (!hit && map_v_q[i] && (map_log_q[i] == addr_q)) begin
        hit     = 1'b1;
        hit_phy = map_phy_q[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    len_d        = len_q;
    phys_d       = phys_q;
    ack_d        = ack_q;
    nack_d       = nack_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    done_d       = 1'b0;
    data_req_d   = 1'b0;
    data_valid_d = 1'b0;
    xlate_err_d  = 1'b0;
    scl_d        = 1'b1;
    sda_d        = 1'b1;

    if ((state_q != S_IDLE) && (state_q != S_LOOKUP)) begin
      if (tick_last) begin
        tick_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          rw_d    = rw;
          addr_d  = addr;
          len_d   = len;
          nack_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        tick_d  = '0;
        phase_d = '0;
        if (hit) begin
          phys_d  = hit_phy;
          state_d = S_START;
        end else begin
`ifdef I2C_XLATE_PASSTHRU_EN
          phys_d  = addr_q;
          state_d = S_START;
`else
          xlate_err_d = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          shift_d = {phys_q, rw_q};
          bit_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_WDATA: begin
        if (data_req_q) shift_d = data_in;
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = (state_q == S_ADDR) ? S_AACK : S_WACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_AACK, S_WACK: begin
        if (sample) ack_d = sda_i;
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (state_q == S_AACK) begin
            if (len_q == '0) begin
              state_d = S_STOP;
            end else if (rw_q) begin
              state_d = S_RDATA;
            end else begin
              data_req_d = 1'b1;
              state_d    = S_WDATA;
            end
          end else begin
            len_d = len_q - 8'd1;
            if (len_q == 8'd1) begin
              state_d = S_STOP;
            end else begin
              data_req_d = 1'b1;
              state_d    = S_WDATA;
            end
          end
        end
      end
      S_RDATA: begin
        if (sample) shift_d = {shift_q[6:0], sda_i};
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            len_d        = len_q - 8'd1;
            bit_d        = '0;
            state_d      = S_MACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_MACK: begin
        if (bit_end) state_d = (len_q == '0) ? S_STOP : S_RDATA;
      end
      S_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pad levels follow the upcoming state/phase so they register in step with it.
    case (state_d)
      S_START: begin
        scl_d = (phase_d != 2'd3);
        sda_d = !phase_d[1];
      end
      S_ADDR, S_WDATA: begin
        scl_d = ^phase_d;
        sda_d = shift_d[7];
      end
      S_AACK, S_WACK, S_RDATA: scl_d = ^phase_d;
      S_MACK: begin
        scl_d = ^phase_d;
        sda_d = (len_d == '0);
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        sda_d = phase_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      phase_q      <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      phys_q       <= '0;
      ack_q        <= 1'b1;
      nack_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_req_q   <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
      xlate_err_q  <= 1'b0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      map_v_q      <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      phys_q       <= phys_d;
      ack_q        <= ack_d;
      nack_q       <= nack_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      data_req_q   <= data_req_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
      xlate_err_q  <= xlate_err_d;
      scl_q        <= scl_d;
      sda_q        <= sda_d;
      if (map_wr) map_v_q[map_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (map_wr) begin
      map_log_q[map_idx] <= map_log;
      map_phy_q[map_idx] <= map_phy;
    end
  end

  assign data_req   = data_req_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign nack       = nack_q;
  assign xlate_err  = xlate_err_q;
  assign scl_o      = scl_q;
  assign sda_o      = sda_q;

endmodule
